dmem_io_bridge: RTL and testbench
=================================

// Module: dmem_io_bridge
// PURPOSE
// - Data-side memory subsystem directly downstream of the single-cycle ARM core's data port.
// - Consumes memaddr/memwrite/memread/be/writedata; returns readdata in the same cycle.
// - Decodes the address into byte-enabled data RAM, a down-counting timer and a GPIO output register.
// - Timer drives the core's active-low nIRQ input.
// PARAMETERS
// - RAM_WORDS  1024          data RAM depth in 32-bit words; power of 2.
// - IO_BASE    16'hFFFF      memaddr[31:16] value that selects the IO region.
// - GPIO_W     8             width of the GPIO output register.
// PORTS
// - clk        in   1        clock, rising edge.
// - reset      in   1        asynchronous, active-low reset.
// - memaddr    in   32       byte address from the core ALU; bits [1:0] ignored.
// - memwrite   in   1        write strobe, sampled at posedge clk.
// - memread    in   1        read qualifier; readdata = 0 when low.
// - be         in   4        byte lane enables; be[i] covers writedata[8i+7:8i].
// - writedata  in   32       store data.
// - readdata   out  32       load data, combinational from memaddr.
// - nIRQ       out  1        active-low interrupt to the core.
// - gpio_out   out  GPIO_W   GPIO register contents.
// - bus_err    out  1        sticky: access to an unmapped address.
// BEHAVIOUR
// - Map:
//   - RAM: memaddr < RAM_WORDS*4.
//   - IO: memaddr[31:16]==IO_BASE, offset memaddr[7:0].
//   - Anything else is unmapped.
// - IO registers:
//   - 0x00 CTRL: [0] EN, [1] IRQEN, [2] AUTO.
//   - 0x04 LOAD.
//   - 0x08 COUNT (read-only).
//   - 0x0C STATUS: [0] PEND, write-1-to-clear.
//   - 0x10 GPIO.
// - Reads: zero latency, combinational.
//   - Unmapped address, undefined IO offset or memread=0 -> readdata = 0.
// - Writes: commit at posedge clk when memwrite=1, per enabled byte lane (RAM and IO alike).
//   - A write to COUNT is ignored.
// - Unmapped access with memread or memwrite high -> bus_err <= 1 until reset.
// - Reset (async, active-low):
//   - CTRL, LOAD, COUNT, PEND, GPIO and bus_err clear to 0; nIRQ = 1.
//   - RAM contents are not reset.
//   - A write coincident with reset assertion is discarded.
// - Timer, per clk while EN=1:
//   - COUNT != 0 -> COUNT - 1.
//   - COUNT == 0 -> PEND <= 1 (expiry).
//     - AUTO=1: COUNT <= LOAD and EN stays 1.
//     - AUTO=0: EN <= 0 and COUNT stays 0.
// - Timer side effects:
//   - A LOAD write also sets COUNT <= new LOAD value; this overrides the decrement in that cycle.
//   - A CTRL write taking EN 0->1 sets COUNT <= LOAD.
//   - AUTO=1 with LOAD=0 -> expiry every cycle.
// - Simultaneous events:
//   - Expiry and a STATUS W1C in the same cycle -> PEND stays 1 (set wins).
//   - CTRL write clearing EN in the expiry cycle -> the write wins (EN=0) and PEND is still set.
// - nIRQ = ~(PEND & IRQEN), combinational from registers.
//   - Clearing IRQEN masks the interrupt without clearing PEND.
// - Arithmetic: COUNT is 32-bit unsigned and never wraps below 0.
// STRUCTURE
// - Package dmem_pkg:
//   - IO_BASE default.
//   - Register offsets (OFS_CTRL, OFS_LOAD, OFS_COUNT, OFS_STATUS, OFS_GPIO).
//   - CTRL bit indices.
//   - Region-select encoding (SEL_RAM, SEL_IO, SEL_NONE).
// - Sub-module periph_timer:
//   - Owns CTRL, LOAD, COUNT, PEND and nIRQ.
//   - Takes decoded write strobes, byte enables and writedata; returns the read mux for its offsets.
// - Top level holds the address decoder, RAM array, GPIO register, bus_err and the readdata mux.
// TESTING
// - RAM byte lanes:
//   - Write 0xA1B2C3D4 to 0x40 with be=1111, then write 0xFFFFFFFF with be=0101.
//   - Required: read of 0x40 returns 0xA1FFC3FF.
// - One-shot timer:
//   - Write LOAD=3, then CTRL=0x3.
//   - Required: COUNT reads 3,2,1,0; PEND=1 and nIRQ=0 on the 4th edge after the CTRL write; EN reads 0.
// - Auto-reload and clear:
//   - Write LOAD=2, then CTRL=0x7.
//   - Required: PEND sets every 3 cycles.
//   - Write STATUS=1 in a non-expiry cycle -> nIRQ=1 next cycle.
//   - Write STATUS=1 in an expiry cycle -> PEND stays 1.
// - Masking:
//   - With PEND=1, write CTRL=0x1.
//   - Required: nIRQ=1 and STATUS reads 1; then write CTRL=0x3 -> nIRQ=0.
// - Unmapped access:
//   - Read 0x8000_0000 with memread=1.
//   - Required: readdata=0 and bus_err=1 after the edge; a following RAM access leaves bus_err at 1.
// - Reset mid-count:
//   - Assert reset asynchronously with COUNT=5 and GPIO=0x5A.
//   - Required: COUNT, GPIO, PEND and bus_err read 0 immediately; nIRQ=1; RAM word at 0x40 keeps its value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory/IO bridge: IO register map,
// CTRL bit positions, region-select encoding and a byte-lane merge helper.
package dmem_pkg;

  localparam logic [15:0] IO_BASE_DEF = 16'hFFFF;

  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_LOAD   = 8'h04;
  localparam logic [7:0] OFS_COUNT  = 8'h08;
  localparam logic [7:0] OFS_STATUS = 8'h0C;
  localparam logic [7:0] OFS_GPIO   = 8'h10;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_IRQEN = 1;
  localparam int unsigned CTRL_AUTO  = 2;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be_v);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be_v[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/periph_timer.sv
// Down-counting timer with auto-reload and a pending flag driving an
// active-low interrupt; owns CTRL, LOAD, COUNT and STATUS.
module periph_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_ctrl_i,
  input  logic        wr_load_i,
  input  logic        wr_status_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  rd_ofs_i,
  output logic [31:0] rdata_o,
  output logic        rd_hit_o,
  output logic        nirq_o
);

  logic [2:0]  ctrl_q,  ctrl_d;
  logic [31:0] load_q,  load_d;
  logic [31:0] count_q, count_d;
  logic        pend_q,  pend_d;
  logic        expire_s;
  logic [31:0] load_new_s;

  // Next-state: timer step first, then bus writes override in priority order.
  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    count_d    = count_q;
    pend_d     = pend_q;
    expire_s   = ctrl_q[CTRL_EN] && (count_q == 32'd0);
    load_new_s = be_merge(load_q, wdata_i, be_i);

    if (ctrl_q[CTRL_EN]) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (ctrl_q[CTRL_AUTO]) begin
        count_d = load_q;
      end else begin
        ctrl_d[CTRL_EN] = 1'b0;
      end
    end else begin
      count_d = count_q;
    end

    if (wr_status_i && be_i[0] && wdata_i[0]) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    // Expiry beats a same-cycle clear so an event is never lost.
    if (expire_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end

    if (wr_ctrl_i && be_i[0]) begin
      ctrl_d = wdata_i[2:0];
      if (!ctrl_q[CTRL_EN] && wdata_i[CTRL_EN]) begin
        count_d = load_q;
      end else begin
        count_d = count_d;
      end
    end else begin
      ctrl_d = ctrl_d;
    end

    if (wr_load_i) begin
      load_d  = load_new_s;
      count_d = load_new_s;
    end else begin
      load_d  = load_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= 3'd0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      pend_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  // Read mux for the timer's own offsets.
  always_comb begin
    rdata_o  = 32'd0;
    rd_hit_o = 1'b1;
    case (rd_ofs_i)
      OFS_CTRL:   rdata_o = {29'd0, ctrl_q};
      OFS_LOAD:   rdata_o = load_q;
      OFS_COUNT:  rdata_o = count_q;
      OFS_STATUS: rdata_o = {31'd0, pend_q};
      default: begin
        rdata_o  = 32'd0;
        rd_hit_o = 1'b0;
      end
    endcase
  end

  assign nirq_o = ~(pend_q & ctrl_q[CTRL_IRQEN]);

endmodule

// File: rtl/dmem_io_bridge.sv
// Data-port memory subsystem: address decode into byte-enabled RAM, the
// timer block and a GPIO register, with a sticky unmapped-access flag.
module dmem_io_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned  RAM_WORDS = 1024,
  parameter logic [15:0]  IO_BASE   = IO_BASE_DEF,
  parameter int unsigned  GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       memaddr,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [3:0]        be,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              nIRQ,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              bus_err
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  sel_e              sel_s;
  logic [AW-1:0]     ram_idx_s;
  logic [7:0]        io_ofs_s;
  logic              io_we_s;
  logic              ram_we_s;
  logic [31:0]       tmr_rdata_s;
  logic              tmr_hit_s;
  logic [31:0]       gpio_ext_s;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       ram_q [RAM_WORDS];

  assign ram_idx_s = memaddr[AW+1:2];
  assign io_ofs_s  = {memaddr[7:2], 2'b00};
  assign io_we_s   = memwrite && (sel_s == SEL_IO);
  assign ram_we_s  = memwrite && (sel_s == SEL_RAM);

  // Region decode; RAM takes precedence should the regions ever overlap.
  always_comb begin
    if ({1'b0, memaddr} < RAM_BYTES) begin
      sel_s = SEL_RAM;
    end else if (memaddr[31:16] == IO_BASE) begin
      sel_s = SEL_IO;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  periph_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .wr_ctrl_i   (io_we_s && (io_ofs_s == OFS_CTRL)),
    .wr_load_i   (io_we_s && (io_ofs_s == OFS_LOAD)),
    .wr_status_i (io_we_s && (io_ofs_s == OFS_STATUS)),
    .be_i        (be),
    .wdata_i     (writedata),
    .rd_ofs_i    (io_ofs_s),
    .rdata_o     (tmr_rdata_s),
    .rd_hit_o    (tmr_hit_s),
    .nirq_o      (nIRQ)
  );

  // RAM byte-lane writes; gated by reset so a write racing reset assertion is dropped.
  always_ff @(posedge clk) begin
    if (ram_we_s && reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          ram_q[ram_idx_s][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  // GPIO next state per byte lane, plus sticky bus error.
  always_comb begin
    gpio_d    = gpio_q;
    bus_err_d = bus_err_q;
    if (io_we_s && (io_ofs_s == OFS_GPIO)) begin
      for (int i = 0; i < int'(GPIO_W); i++) begin
        if (be[i/8]) begin
          gpio_d[i] = writedata[i];
        end
      end
    end else begin
      gpio_d = gpio_q;
    end
    if ((sel_s == SEL_NONE) && (memread || memwrite)) begin
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = bus_err_q;
    end
  end

  // GPIO and bus error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      gpio_q    <= gpio_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Zero-extend GPIO for the read path.
  always_comb begin
    gpio_ext_s = 32'd0;
    gpio_ext_s[GPIO_W-1:0] = gpio_q;
  end

  // Combinational load data; zero unless qualified by memread and a defined target.
  always_comb begin
    readdata = 32'd0;
    if (memread) begin
      case (sel_s)
        SEL_RAM: readdata = ram_q[ram_idx_s];
        SEL_IO: begin
          if (tmr_hit_s) begin
            readdata = tmr_rdata_s;
          end else if (io_ofs_s == OFS_GPIO) begin
            readdata = gpio_ext_s;
          end else begin
            readdata = 32'd0;
          end
        end
        default: readdata = 32'd0;
      endcase
    end else begin
      readdata = 32'd0;
    end
  end

  assign gpio_out = gpio_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Scoreboard bench for dmem_io_bridge: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dmem_io_bridge;

  localparam logic [31:0] A_CTRL  = 32'hFFFF_0000;
  localparam logic [31:0] A_LOAD  = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT  = 32'hFFFF_000C;
  localparam logic [31:0] A_GPIO  = 32'hFFFF_0010;
  localparam logic [31:0] A_BADIO = 32'hFFFF_0014;
  localparam logic [31:0] A_RAM   = 32'h0000_0040;
  localparam logic [31:0] A_UNMAP = 32'h8000_0000;

  localparam int K_RD   = 1;
  localparam int K_NIRQ = 2;
  localparam int K_BERR = 3;
  localparam int K_GPIO = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic [31:0] memaddr   = 32'd0;
  logic        memwrite  = 1'b0;
  logic        memread   = 1'b0;
  logic [3:0]  be        = 4'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        nIRQ;
  logic [7:0]  gpio_out;
  logic        bus_err;

  int          checks   = 0;
  int          failures = 0;
  logic        chk_req  = 1'b0;
  int          kind_q[$];
  logic [31:0] val_q[$];
  string       tag_q[$];

  int          m_kind;
  logic [31:0] m_exp;
  logic [31:0] m_act;
  string       m_tag;

  dmem_io_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .memaddr   (memaddr),
    .memwrite  (memwrite),
    .memread   (memread),
    .be        (be),
    .writedata (writedata),
    .readdata  (readdata),
    .nIRQ      (nIRQ),
    .gpio_out  (gpio_out),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive, optionally queue an expectation, then step past the edge.
  task automatic cyc(input logic [31:0] a, input logic we, input logic rd,
                     input logic [3:0] b, input logic [31:0] d,
                     input int k, input logic [31:0] e, input string t);
    memaddr   = a;
    memwrite  = we;
    memread   = rd;
    be        = b;
    writedata = d;
    if (k != 0) begin
      kind_q.push_back(k);
      val_q.push_back(e);
      tag_q.push_back(t);
      chk_req = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_req   = 1'b0;
    memaddr   = 32'd0;
    memwrite  = 1'b0;
    memread   = 1'b0;
    be        = 4'd0;
    writedata = 32'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    cyc(a, 1'b1, 1'b0, b, d, 0, 32'd0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
    cyc(a, 1'b0, 1'b1, 4'hF, 32'd0, K_RD, e, t);
  endtask

  task automatic chk(input int k, input logic [31:0] e, input string t);
    cyc(32'd0, 1'b0, 1'b0, 4'h0, 32'd0, k, e, t);
  endtask

  // Monitor: compares the oldest expectation against the selected DUT output.
  always @(negedge clk) begin
    if (chk_req) begin
      checks = checks + 1;
      if (kind_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL scoreboard_underflow: got no expectation, required one");
      end else begin
        m_kind = kind_q.pop_front();
        m_exp  = val_q.pop_front();
        m_tag  = tag_q.pop_front();
        case (m_kind)
          K_RD:    m_act = readdata;
          K_NIRQ:  m_act = {31'd0, nIRQ};
          K_BERR:  m_act = {31'd0, bus_err};
          K_GPIO:  m_act = {24'd0, gpio_out};
          default: m_act = 32'hDEAD_BEEF;
        endcase
        if (m_act !== m_exp) begin
          failures = failures + 1;
          $display("FAIL %s: got %h required %h", m_tag, m_act, m_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    chk(K_NIRQ, 32'd1, "rst_nirq");
    chk(K_BERR, 32'd0, "rst_buserr");
    chk(K_GPIO, 32'd0, "rst_gpio");
    rd(A_CTRL,  32'd0, "rst_ctrl");
    rd(A_COUNT, 32'd0, "rst_count");

    // RAM byte lanes and read qualifier
    wr(A_RAM, 32'hA1B2_C3D4, 4'hF);
    wr(A_RAM, 32'hFFFF_FFFF, 4'h5);
    rd(A_RAM, 32'hA1FF_C3FF, "ram_lanes");
    cyc(A_RAM, 1'b0, 1'b0, 4'hF, 32'd0, K_RD, 32'd0, "memread_low");

    // GPIO, undefined offset, COUNT write ignored
    wr(A_GPIO, 32'h0000_005A, 4'h1);
    rd(A_GPIO, 32'h0000_005A, "gpio_rd");
    wr(A_GPIO, 32'h0000_3300, 4'h2);
    chk(K_GPIO, 32'h5A, "gpio_lane_off");
    rd(A_BADIO, 32'd0, "io_undef_ofs");
    wr(A_COUNT, 32'h55, 4'hF);
    rd(A_COUNT, 32'd0, "count_wr_ignored");
    chk(K_BERR, 32'd0, "no_buserr_io");

    // One-shot timer
    wr(A_LOAD, 32'd3, 4'hF);
    wr(A_CTRL, 32'h3, 4'hF);
    rd(A_COUNT, 32'd3, "os_count3");
    rd(A_COUNT, 32'd2, "os_count2");
    rd(A_COUNT, 32'd1, "os_count1");
    rd(A_COUNT, 32'd0, "os_count0");
    chk(K_NIRQ, 32'd0, "os_nirq");
    rd(A_STAT, 32'd1, "os_pend");
    rd(A_CTRL, 32'h2, "os_en_clear");

    // Masking
    wr(A_CTRL, 32'h1, 4'hF);
    chk(K_NIRQ, 32'd1, "mask_nirq");
    rd(A_STAT, 32'd1, "mask_pend_kept");
    wr(A_CTRL, 32'h3, 4'hF);
    chk(K_NIRQ, 32'd0, "unmask_nirq");
    wr(A_STAT, 32'd1, 4'hF);
    chk(K_NIRQ, 32'd1, "w1c_nirq");

    // Auto-reload, period 3, W1C interactions
    wr(A_LOAD, 32'd2, 4'hF);
    wr(A_CTRL, 32'h7, 4'hF);
    rd(A_COUNT, 32'd2, "ar_count2");
    rd(A_COUNT, 32'd1, "ar_count1");
    rd(A_STAT, 32'd0, "ar_pend_before");
    wr(A_STAT, 32'd1, 4'hF);
    chk(K_NIRQ, 32'd1, "ar_w1c_nonexp");
    wr(A_STAT, 32'd1, 4'hF);
    rd(A_STAT, 32'd1, "ar_w1c_exp_setwins");
    rd(A_COUNT, 32'd1, "ar_reload");
    chk(K_NIRQ, 32'd0, "ar_nirq_low");
    wr(A_STAT, 32'd1, 4'hF);
    rd(A_STAT, 32'd0, "ar_period_a");
    rd(A_STAT, 32'd0, "ar_period_b");
    rd(A_STAT, 32'd1, "ar_period_set");

    // CTRL write clearing EN in an expiry cycle
    wr(A_STAT, 32'd1, 4'hF);
    wr(A_CTRL, 32'h2, 4'hF);
    rd(A_STAT, 32'd1, "ctrl_exp_pend");
    rd(A_CTRL, 32'h2, "ctrl_exp_en0");

    // AUTO with LOAD=0 expires every cycle
    wr(A_LOAD, 32'd0, 4'hF);
    wr(A_CTRL, 32'h7, 4'hF);
    wr(A_STAT, 32'd1, 4'hF);
    rd(A_STAT, 32'd1, "load0_every_cycle");
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_STAT, 32'd1, 4'hF);
    rd(A_STAT, 32'd0, "stopped_clear");

    // Unmapped access
    rd(A_UNMAP, 32'd0, "unmapped_rd");
    chk(K_BERR, 32'd1, "buserr_set");
    rd(A_RAM, 32'hA1FF_C3FF, "ram_after_err");
    chk(K_BERR, 32'd1, "buserr_sticky");

    // Reset mid-count with COUNT=5, GPIO=0x5A
    wr(A_LOAD, 32'd7, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    rd(A_COUNT, 32'd7, "pre_rst_count7");
    rd(A_COUNT, 32'd6, "pre_rst_count6");
    #1;
    reset = 1'b0;
    rd(A_COUNT, 32'd0, "rst_mid_count");
    chk(K_GPIO, 32'd0, "rst_mid_gpio");
    rd(A_STAT, 32'd0, "rst_mid_pend");
    chk(K_BERR, 32'd0, "rst_mid_buserr");
    chk(K_NIRQ, 32'd1, "rst_mid_nirq");
    wr(A_RAM, 32'h0000_0000, 4'hF);
    rd(A_RAM, 32'hA1FF_C3FF, "rst_ram_kept");
    reset = 1'b1;
    rd(A_CTRL, 32'd0, "post_rst_ctrl");

    repeat (2) @(posedge clk);
    if (kind_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_leftover: got %0d pending, required 0", kind_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
